// File: rtl/cp0_reg_dump.sv
// Walks compact CP0 indices, reads each architectural (rd,sel) over the CP0 read
// port and streams {idx,rd,sel,data} records to a valid/ready consumer.
module cp0_reg_dump #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LAST_IDX = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [5:0]        first_idx,
  output logic              cp0_req,
  output logic [4:0]        cp0_rd,
  output logic [2:0]        cp0_sel,
  input  logic              cp0_ack,
  input  logic [DATA_W-1:0] cp0_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        out_idx,
  output logic [4:0]        out_rd,
  output logic [2:0]        out_sel,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [5:0] LAST = 6'(LAST_IDX);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_OUT} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [5:0]          r_idx;
  logic [5:0]          r_out_idx;
  logic [4:0]          r_out_rd;
  logic [2:0]          r_out_sel;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_done;
  logic                r_err;
  logic [7:0]          w_map;
  logic                w_first_ok;
  logic                w_last;

  // Compact index -> {rd[4:0], sel[2:0]}; unimplemented indices map to 0.
  function automatic logic [7:0] idx_map(input logic [5:0] idx);
    logic [7:0] m;
    case (idx)
      6'd0:  m = {5'd7,  3'd0};
      6'd1:  m = {5'd8,  3'd0};
      6'd2:  m = {5'd9,  3'd0};
      6'd3:  m = {5'd11, 3'd0};
      6'd4:  m = {5'd12, 3'd1};
      6'd5:  m = {5'd12, 3'd2};
      6'd6:  m = {5'd12, 3'd3};
      6'd7:  m = {5'd12, 3'd0};
      6'd8:  m = {5'd13, 3'd0};
      6'd9:  m = {5'd14, 3'd0};
      6'd10: m = {5'd15, 3'd1};
      6'd11: m = {5'd15, 3'd0};
      6'd12: m = {5'd16, 3'd1};
      6'd13: m = {5'd16, 3'd2};
      6'd14: m = {5'd16, 3'd3};
      6'd15: m = {5'd16, 3'd0};
      6'd16: m = {5'd17, 3'd0};
      6'd17: m = {5'd18, 3'd0};
      6'd18: m = {5'd19, 3'd0};
      6'd19: m = {5'd23, 3'd0};
      6'd20: m = {5'd24, 3'd0};
      6'd21: m = {5'd25, 3'd0};
      6'd22: m = {5'd25, 3'd1};
      6'd23: m = {5'd26, 3'd0};
      6'd24: m = {5'd27, 3'd0};
      6'd25: m = {5'd28, 3'd1};
      6'd26: m = {5'd28, 3'd0};
      6'd27: m = {5'd29, 3'd0};
      6'd28: m = {5'd29, 3'd1};
      6'd29: m = {5'd30, 3'd0};
      6'd30: m = {5'd31, 3'd0};
      default: m = '0;
    endcase
    return m;
  endfunction

  assign w_map      = idx_map(r_idx);
  assign w_first_ok = (first_idx <= LAST);
  assign w_last     = (r_idx == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start && w_first_ok) w_next = S_REQ;
        S_REQ:   if (cp0_ack)             w_next = S_OUT;
        S_OUT:   if (out_ready)           w_next = w_last ? S_IDLE : S_REQ;
        default:                          w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cp0_req   = 1'b0;
    cp0_rd    = '0;
    cp0_sel   = '0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_REQ: begin
        cp0_req           = 1'b1;
        {cp0_rd, cp0_sel} = w_map;
        busy              = 1'b1;
      end
      S_OUT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_out_idx  <= '0;
      r_out_rd   <= '0;
      r_out_sel  <= '0;
      r_out_data <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (abort) begin
        // Abort also clears the record fields so every output reads 0 afterwards.
        r_idx      <= '0;
        r_out_idx  <= '0;
        r_out_rd   <= '0;
        r_out_sel  <= '0;
        r_out_data <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (w_first_ok) r_idx <= first_idx;
              else            r_err <= 1'b1;
            end
          end
          S_REQ: begin
            if (cp0_ack) begin
              r_out_idx              <= r_idx;
              {r_out_rd, r_out_sel}  <= w_map;
              r_out_data             <= cp0_data;
            end
          end
          S_OUT: begin
            if (out_ready) begin
              if (w_last) r_done <= 1'b1;
              else        r_idx  <= r_idx + 6'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign out_idx  = r_out_idx;
  assign out_rd   = r_out_rd;
  assign out_sel  = r_out_sel;
  assign out_data = r_out_data;
  assign done     = r_done;
  assign err      = r_err;

endmodule
